// File: rtl/fp_alu_selftest.sv
// Vector sequencer/checker for one IEEE-754 alu: replays stored vectors through the
// start/valid_out handshake and accumulates pass/fail statistics with first-failure capture.
module fp_alu_selftest #(
  parameter int DEPTH     = 16,
  parameter int TIMEOUT   = 5000,
  parameter int CMP_FLAGS = 1,
  parameter int CW        = 16,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vec_we,
  input  logic [AW-1:0] vec_addr,
  input  logic [31:0]   vec_a,
  input  logic [31:0]   vec_b,
  input  logic [2:0]    vec_op,
  input  logic          vec_mode,
  input  logic          vec_round,
  input  logic [31:0]   vec_exp_result,
  input  logic [4:0]    vec_exp_flags,
  input  logic [AW:0]   num_vectors,
  input  logic          run,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] pass_count,
  output logic [CW-1:0] fail_count,
  output logic          timeout_err,
  output logic [AW-1:0] first_fail_idx,
  output logic [31:0]   first_fail_result,
  output logic [4:0]    first_fail_flags,
  output logic [31:0]   alu_op_a,
  output logic [31:0]   alu_op_b,
  output logic [2:0]    alu_op_code,
  output logic          alu_mode_fp,
  output logic          alu_round_mode,
  output logic          alu_start,
  input  logic [31:0]   alu_result,
  input  logic          alu_valid_out,
  input  logic [4:0]    alu_flags
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_CHECK, S_DONE} state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        mode;
    logic        rnd;
    logic [31:0] exp_res;
    logic [4:0]  exp_flags;
  } vec_t;

  vec_t          mem [DEPTH];
  vec_t          rd_vec;
  state_t        state, state_nx;
  logic [AW:0]   n_lat;
  logic [AW-1:0] idx;
  logic [TW-1:0] timer;
  logic          timer_hit, tmo, first_seen;
  logic [31:0]   exp_res_q, cap_result;
  logic [4:0]    exp_flags_q, cap_flags;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  // HP results live in the low half; the upper 16 bits are don't-care in HP mode.
  function automatic logic resp_match(input logic sp, input logic [31:0] res,
                                      input logic [31:0] exp_res, input logic [4:0] fl,
                                      input logic [4:0] exp_fl);
    logic ok;
    ok = sp ? (res == exp_res) : (res[15:0] == exp_res[15:0]);
    if (CMP_FLAGS != 0) ok = ok && (fl == exp_fl);
    return ok;
  endfunction

  assign busy      = (state == S_LOAD) || (state == S_ISSUE) || (state == S_DRAIN) ||
                     (state == S_CHECK);
  assign done      = (state == S_DONE);
  assign rd_vec    = mem[idx];
  assign timer_hit = (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (vec_we && !busy)
      mem[vec_addr] <= '{a: vec_a, b: vec_b, op: vec_op, mode: vec_mode, rnd: vec_round,
                         exp_res: vec_exp_result, exp_flags: vec_exp_flags};
  end

  always_comb begin
    state_nx = state;
    tmo      = 1'b0;
    case (state)
      S_IDLE:  if (run) state_nx = (num_vectors != '0) ? S_LOAD : S_DONE;
      S_LOAD:  state_nx = S_ISSUE;
      S_ISSUE: begin
        if (alu_valid_out) state_nx = S_DRAIN;
        else if (timer_hit) begin
          tmo      = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_DRAIN: begin
        if (!alu_valid_out) state_nx = S_CHECK;
        else if (timer_hit) begin
          tmo      = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_CHECK: state_nx = ({1'b0, idx} == n_lat - 1'b1) ? S_DONE : S_LOAD;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      n_lat             <= '0;
      idx               <= '0;
      timer             <= '0;
      first_seen        <= 1'b0;
      alu_start         <= 1'b0;
      pass_count        <= '0;
      fail_count        <= '0;
      timeout_err       <= 1'b0;
      first_fail_idx    <= '0;
      first_fail_result <= '0;
      first_fail_flags  <= '0;
      alu_op_a          <= '0;
      alu_op_b          <= '0;
      alu_op_code       <= '0;
      alu_mode_fp       <= 1'b0;
      alu_round_mode    <= 1'b0;
    end else begin
      state     <= state_nx;
      alu_start <= (state_nx == S_ISSUE);
      if ((state_nx == S_ISSUE || state_nx == S_DRAIN) && state_nx != state)
        timer <= '0;
      else if (state == S_ISSUE || state == S_DRAIN)
        timer <= timer + 1'b1;
      if (state == S_LOAD) begin
        alu_op_a       <= rd_vec.a;
        alu_op_b       <= rd_vec.b;
        alu_op_code    <= rd_vec.op;
        alu_mode_fp    <= rd_vec.mode;
        alu_round_mode <= rd_vec.rnd;
      end
      if (state == S_IDLE && run) begin
        n_lat             <= num_vectors;
        idx               <= '0;
        pass_count        <= '0;
        fail_count        <= '0;
        timeout_err       <= 1'b0;
        first_seen        <= 1'b0;
        first_fail_idx    <= '0;
        first_fail_result <= '0;
        first_fail_flags  <= '0;
      end else if (state == S_CHECK) begin
        if (resp_match(alu_mode_fp, cap_result, exp_res_q, cap_flags, exp_flags_q)) begin
          pass_count <= sat_inc(pass_count);
        end else begin
          fail_count <= sat_inc(fail_count);
          if (!first_seen) begin
            first_seen        <= 1'b1;
            first_fail_idx    <= idx;
            first_fail_result <= cap_result;
            first_fail_flags  <= cap_flags;
          end
        end
        if (state_nx == S_LOAD) idx <= idx + 1'b1;
      end else if (tmo) begin
        // A timeout in ISSUE has no response to report, so the capture is zeroed.
        timeout_err <= 1'b1;
        fail_count  <= sat_inc(fail_count);
        if (!first_seen) begin
          first_seen        <= 1'b1;
          first_fail_idx    <= idx;
          first_fail_result <= (state == S_ISSUE) ? 32'h0 : cap_result;
          first_fail_flags  <= (state == S_ISSUE) ? 5'h0 : cap_flags;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_LOAD) begin
      exp_res_q   <= rd_vec.exp_res;
      exp_flags_q <= rd_vec.exp_flags;
    end
    if (state == S_ISSUE && alu_valid_out) begin
      cap_result <= alu_result;
      cap_flags  <= alu_flags;
    end
  end

endmodule

// File: tb/tb_fp_alu_selftest.sv
// Bench for fp_alu_selftest: two instances (flags compared / not compared) share the loader,
// each driven by a latency-3 behavioural ALU; results are checked against a vector-list model.
`timescale 1ns/1ps
module tb_fp_alu_selftest;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vec_we = 1'b0;
  logic [3:0]  vec_addr = '0;
  logic [31:0] vec_a = '0, vec_b = '0, vec_exp_result = '0;
  logic [2:0]  vec_op = '0;
  logic        vec_mode = 1'b0, vec_round = 1'b0;
  logic [4:0]  vec_exp_flags = '0;
  logic [4:0]  num_vectors = '0;
  logic        run = 1'b0;
  logic        alu_silent = 1'b0;
  int          ncmp = 0, nfail = 0;
  int          dp_base [2];

  logic [31:0] sh_a [DEPTH], sh_b [DEPTH], sh_er [DEPTH];
  logic [2:0]  sh_op [DEPTH];
  logic        sh_mode [DEPTH], sh_rnd [DEPTH];
  logic [4:0]  sh_ef [DEPTH];

  logic        busy_a [2], done_a [2], tmo_a [2], start_a [2];
  logic [15:0] pass_a [2], fail_a [2];
  logic [3:0]  ffi_a [2];
  logic [31:0] ffr_a [2], opa_a [2];
  logic [4:0]  fff_a [2];
  int          dp_a [2];

  always #5 clk = ~clk;

  // Behavioural ALU: a few known IEEE cases, otherwise a simple deterministic response.
  function automatic logic [36:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op, input logic rnd);
    if (op == 3'd0 && a == 32'h40A00000 && b == 32'h40A00000) return {5'b00000, 32'h41200000};
    if (op == 3'd1 && a == 32'h7F800000 && b == 32'h7F800000) return {5'b10000, 32'h7FC00000};
    if (op == 3'd2 && a == 32'h00004000 && b == 32'h00004200) return {5'b00000, 32'hDEAD4600};
    return {a[4:0] ^ b[4:0], a + b + {29'b0, op} + {31'b0, rnd}};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        busy, done, timeout_err, alu_start, alu_mode_fp, alu_round_mode;
    logic [15:0] pass_count, fail_count;
    logic [3:0]  first_fail_idx;
    logic [31:0] first_fail_result, alu_op_a, alu_op_b;
    logic [4:0]  first_fail_flags;
    logic [2:0]  alu_op_code;
    logic [31:0] alu_result = '0;
    logic        alu_valid_out = 1'b0;
    logic [4:0]  alu_flags = '0;
    int          mcnt = 0, dpulses = 0;

    fp_alu_selftest #(.DEPTH(DEPTH), .TIMEOUT(20), .CMP_FLAGS(g == 0 ? 1 : 0), .CW(16)) u_dut (
      .clk(clk), .rst(rst), .vec_we(vec_we), .vec_addr(vec_addr), .vec_a(vec_a),
      .vec_b(vec_b), .vec_op(vec_op), .vec_mode(vec_mode), .vec_round(vec_round),
      .vec_exp_result(vec_exp_result), .vec_exp_flags(vec_exp_flags),
      .num_vectors(num_vectors), .run(run), .busy(busy), .done(done),
      .pass_count(pass_count), .fail_count(fail_count), .timeout_err(timeout_err),
      .first_fail_idx(first_fail_idx), .first_fail_result(first_fail_result),
      .first_fail_flags(first_fail_flags), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
      .alu_op_code(alu_op_code), .alu_mode_fp(alu_mode_fp), .alu_round_mode(alu_round_mode),
      .alu_start(alu_start), .alu_result(alu_result), .alu_valid_out(alu_valid_out),
      .alu_flags(alu_flags));

    always @(posedge clk) begin
      if (!alu_start) begin
        alu_valid_out <= 1'b0;
        mcnt          <= 0;
      end else if (!alu_valid_out && !alu_silent) begin
        if (mcnt == 2) begin
          alu_valid_out         <= 1'b1;
          {alu_flags, alu_result} <= alu_fn(alu_op_a, alu_op_b, alu_op_code, alu_round_mode);
        end else begin
          mcnt <= mcnt + 1;
        end
      end
      if (done) dpulses <= dpulses + 1;
    end

    assign busy_a[g]  = busy;
    assign done_a[g]  = done;
    assign tmo_a[g]   = timeout_err;
    assign start_a[g] = alu_start;
    assign pass_a[g]  = pass_count;
    assign fail_a[g]  = fail_count;
    assign ffi_a[g]   = first_fail_idx;
    assign ffr_a[g]   = first_fail_result;
    assign fff_a[g]   = first_fail_flags;
    assign opa_a[g]   = alu_op_a;
    assign dp_a[g]    = dpulses;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic load_slot(input int addr, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic mode, input logic rnd,
                           input logic [31:0] er, input logic [4:0] ef);
    vec_addr = 4'(addr); vec_a = a; vec_b = b; vec_op = op; vec_mode = mode;
    vec_round = rnd; vec_exp_result = er; vec_exp_flags = ef; vec_we = 1'b1;
    @(negedge clk);
    vec_we = 1'b0;
    sh_a[addr] = a; sh_b[addr] = b; sh_op[addr] = op; sh_mode[addr] = mode;
    sh_rnd[addr] = rnd; sh_er[addr] = er; sh_ef[addr] = ef;
  endtask

  // Stored vector whose expectation equals the model's response, optionally corrupted.
  task automatic load_rand(input int addr, input int kind);
    logic [31:0] a, b, er;
    logic [2:0]  op;
    logic        mode, rnd;
    logic [36:0] r;
    logic [4:0]  ef;
    a = $urandom; b = $urandom; op = 3'($urandom_range(0, 3));
    mode = 1'($urandom_range(0, 1)); rnd = 1'($urandom_range(0, 1));
    r = alu_fn(a, b, op, rnd); er = r[31:0]; ef = r[36:32];
    case (kind)
      0: er = er ^ 32'h1;
      1: ef = ef ^ 5'h1;
      2: er = er ^ 32'h8000_0000;
      default: ;
    endcase
    load_slot(addr, a, b, op, mode, rnd, er, ef);
  endtask

  task automatic ref_run(input int n, input bit cmpf, output int np, output int nf,
                         output logic [3:0] fi, output logic [31:0] fr, output logic [4:0] ff);
    logic [36:0] r;
    bit ok;
    np = 0; nf = 0; fi = '0; fr = '0; ff = '0;
    for (int i = 0; i < n; i++) begin
      r  = alu_fn(sh_a[i], sh_b[i], sh_op[i], sh_rnd[i]);
      ok = sh_mode[i] ? (r[31:0] == sh_er[i]) : (r[15:0] == sh_er[i][15:0]);
      if (cmpf) ok = ok && (r[36:32] == sh_ef[i]);
      if (ok) np++;
      else begin
        if (nf == 0) begin fi = 4'(i); fr = r[31:0]; ff = r[36:32]; end
        nf++;
      end
    end
  endtask

  task automatic start_run(input int n);
    dp_base[0] = dp_a[0]; dp_base[1] = dp_a[1];
    num_vectors = 5'(n); run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while ((dp_a[0] == dp_base[0] || dp_a[1] == dp_base[1]) && k < 3000) begin
      @(negedge clk); k++;
    end
    check({tag, "_done_seen"}, 64'(k < 3000), 64'(1));
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("%s_pulses%0d", tag, g), 64'(dp_a[g] - dp_base[g]), 64'(1));
      check($sformatf("%s_busy%0d", tag, g), 64'(busy_a[g]), 64'(0));
      check($sformatf("%s_start%0d", tag, g), 64'(start_a[g]), 64'(0));
    end
  endtask

  task automatic verify_run(input string tag, input int n);
    int np, nf;
    logic [3:0] fi; logic [31:0] fr; logic [4:0] ff;
    for (int g = 0; g < 2; g++) begin
      ref_run(n, g == 0, np, nf, fi, fr, ff);
      check($sformatf("%s_pass%0d", tag, g), 64'(pass_a[g]), 64'(np));
      check($sformatf("%s_fail%0d", tag, g), 64'(fail_a[g]), 64'(nf));
      check($sformatf("%s_ffidx%0d", tag, g), 64'(ffi_a[g]), 64'(fi));
      check($sformatf("%s_ffres%0d", tag, g), 64'(ffr_a[g]), 64'(fr));
      check($sformatf("%s_fffl%0d", tag, g), 64'(fff_a[g]), 64'(ff));
      check($sformatf("%s_tmo%0d", tag, g), 64'(tmo_a[g]), 64'(0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog observed=expired expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, rises;
    logic prev;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst_busy%0d", g), 64'(busy_a[g]), 64'(0));
      check($sformatf("rst_done%0d", g), 64'(done_a[g]), 64'(0));
      check($sformatf("rst_pass%0d", g), 64'(pass_a[g]), 64'(0));
      check($sformatf("rst_fail%0d", g), 64'(fail_a[g]), 64'(0));
      check($sformatf("rst_start%0d", g), 64'(start_a[g]), 64'(0));
      check($sformatf("rst_opa%0d", g), 64'(opa_a[g]), 64'(0));
    end
    rst = 1'b0;
    @(negedge clk);

    // Two SP vectors that both match.
    load_slot(0, 32'h40A00000, 32'h40A00000, 3'd0, 1'b1, 1'b0, 32'h41200000, 5'b00000);
    load_slot(1, 32'h7F800000, 32'h7F800000, 3'd1, 1'b1, 1'b0, 32'h7FC00000, 5'b10000);
    start_run(2);
    wait_done("t1");
    check("t1_pass_const", 64'(pass_a[0]), 64'(2));
    check("t1_fail_const", 64'(fail_a[0]), 64'(0));
    verify_run("t1", 2);

    // HP compares only the low half; the same vector in SP mode fails.
    load_slot(0, 32'h00004000, 32'h00004200, 3'd2, 1'b0, 1'b0, 32'h00004600, 5'b00000);
    start_run(1);
    wait_done("t2hp");
    check("t2hp_pass", 64'(pass_a[0]), 64'(1));
    verify_run("t2hp", 1);
    load_slot(0, 32'h00004000, 32'h00004200, 3'd2, 1'b1, 1'b0, 32'h00004600, 5'b00000);
    start_run(1);
    wait_done("t2sp");
    check("t2sp_fail", 64'(fail_a[0]), 64'(1));
    check("t2sp_ffres", 64'(ffr_a[0]), 64'(32'hDEAD4600));
    verify_run("t2sp", 1);

    // Flag-only mismatch: counted as a fail only where flags are compared.
    load_slot(0, 32'h10, 32'h10, 3'd0, 1'b1, 1'b0, 32'h20, 5'b00001);
    start_run(1);
    wait_done("t3");
    check("t3_fail_cmp", 64'(fail_a[0]), 64'(1));
    check("t3_pass_nocmp", 64'(pass_a[1]), 64'(1));
    verify_run("t3", 1);

    // Silent ALU: timeout 20 cycles after alu_start rises.
    alu_silent = 1'b1;
    start_run(1);
    k = 0;
    while (!start_a[0] && k < 100) begin @(negedge clk); k++; end
    check("t4_start_seen", 64'(k < 100), 64'(1));
    k = 0;
    while (!done_a[0] && k < 200) begin @(negedge clk); k++; end
    check("t4_done_latency", 64'(k), 64'(20));
    for (int g = 0; g < 2; g++) begin
      check($sformatf("t4_tmo%0d", g), 64'(tmo_a[g]), 64'(1));
      check($sformatf("t4_fail%0d", g), 64'(fail_a[g]), 64'(1));
      check($sformatf("t4_start%0d", g), 64'(start_a[g]), 64'(0));
      check($sformatf("t4_ffres%0d", g), 64'(ffr_a[g]), 64'(0));
    end
    alu_silent = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during ISSUE of vector 3 of 8; a write while busy must be dropped.
    for (int i = 0; i < 8; i++) load_rand(i, (i % 2 == 0) ? 3 : $urandom_range(0, 3));
    start_run(8);
    rises = 0; prev = 1'b0; k = 0;
    while (rises < 4 && k < 2000) begin
      if (start_a[0] && !prev) rises++;
      prev = start_a[0];
      if (rises < 4) begin @(negedge clk); k++; end
    end
    check("t5_reach_v3", 64'(k < 2000), 64'(1));
    check("t5_opa_v3", 64'(opa_a[0]), 64'(sh_a[3]));
    vec_addr = 4'd0; vec_a = ~sh_a[0]; vec_exp_result = ~sh_er[0]; vec_we = 1'b1;
    @(negedge clk);
    vec_we = 1'b0; rst = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("t5_start%0d", g), 64'(start_a[g]), 64'(0));
      check($sformatf("t5_busy%0d", g), 64'(busy_a[g]), 64'(0));
      check($sformatf("t5_pass%0d", g), 64'(pass_a[g]), 64'(0));
      check($sformatf("t5_fail%0d", g), 64'(fail_a[g]), 64'(0));
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t5_no_done", 64'(dp_a[0] - dp_base[0]), 64'(0));
    start_run(8);
    wait_done("t5re");
    verify_run("t5re", 8);

    // All slots, deliberate mismatches at 5..12.
    for (int i = 0; i < DEPTH; i++) load_rand(i, (i >= 5 && i <= 12) ? 0 : 3);
    start_run(DEPTH);
    wait_done("t6");
    check("t6_fail", 64'(fail_a[0]), 64'(8));
    check("t6_pass", 64'(pass_a[0]), 64'(DEPTH - 8));
    check("t6_ffidx", 64'(ffi_a[0]), 64'(5));
    verify_run("t6", DEPTH);
    start_run(DEPTH);
    check("t6_clr_pass", 64'(pass_a[0]), 64'(0));
    check("t6_clr_fail", 64'(fail_a[0]), 64'(0));
    check("t6_busy_run", 64'(busy_a[0]), 64'(1));
    wait_done("t6b");
    verify_run("t6b", DEPTH);

    // Zero-length run: immediate done, counters cleared, never busy.
    start_run(0);
    check("t7_busy", 64'(busy_a[0]), 64'(0));
    check("t7_done", 64'(done_a[0]), 64'(1));
    wait_done("t7");
    check("t7_pass", 64'(pass_a[0]), 64'(0));
    check("t7_fail", 64'(fail_a[1]), 64'(0));

    // Randomised rounds of mixed match/mismatch vectors.
    for (int r = 0; r < 4; r++) begin
      k = $urandom_range(1, DEPTH);
      for (int i = 0; i < k; i++) load_rand(i, $urandom_range(0, 3));
      start_run(k);
      wait_done($sformatf("rnd%0d", r));
      verify_run($sformatf("rnd%0d", r), k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
